// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback port arbiter and its
// long-latency write FIFO.
package wb_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    // One buffered regfile write.
    typedef struct packed {
        logic [REG_W-1:0]  tgt;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // Starvation guard state.
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FORCE
    } arb_state_t;

endpackage

// File: rtl/wb_lat_fifo.sv
// Long-latency write FIFO: circular storage with up to two pops per cycle,
// exposing the two oldest entries and a mask of all buffered targets.
module wb_lat_fifo
    import wb_pkg::*;
#(
    parameter int LAT_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [REG_W-1:0]             push_tgt,
    input  logic [DATA_W-1:0]            push_data,
    input  logic [1:0]                   pop_cnt,
    output logic [REG_W-1:0]             head_tgt,
    output logic [DATA_W-1:0]            head_data,
    output logic [REG_W-1:0]             sec_tgt,
    output logic [DATA_W-1:0]            sec_data,
    output logic [$clog2(LAT_DEPTH):0]   count,
    output logic [NUM_REGS-1:0]          pend_mask
);

    localparam int PTR_W = $clog2(LAT_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t          mem [LAT_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] sec_ptr;
    logic [PTR_W-1:0] scan_ptr;
    logic [CNT_W-1:0] count_q;

    assign sec_ptr   = rd_ptr + PTR_W'(1);
    assign head_tgt  = mem[rd_ptr].tgt;
    assign head_data = mem[rd_ptr].data;
    assign sec_tgt   = mem[sec_ptr].tgt;
    assign sec_data  = mem[sec_ptr].data;
    assign count     = count_q;

    // Entry storage; contents are only meaningful while counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{tgt: push_tgt, data: push_data};
        end
    end

    // Pointers and occupancy; a push and pops in the same cycle net out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr  <= rd_ptr + PTR_W'(pop_cnt);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop_cnt);
        end
    end

    // Target mask of every valid entry, for the hazard unit.
    always_comb begin
        pend_mask = '0;
        scan_ptr  = rd_ptr;
        for (int i = 0; i < LAT_DEPTH; i++) begin
            scan_ptr = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                pend_mask[mem[scan_ptr].tgt] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: pipeline slots own regfile ports A/B, buffered
// long-latency writes drain into idle ports, and an aging counter forces a
// pipeline stall when the buffer is starved.
// Optional build macro WB_ARB_STATS_EN adds stall-cycle and drained-write
// counters (stat_stall_cycles, stat_lat_writes).
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int LAT_DEPTH    = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                p_we1,
    input  logic                p_we2,
    input  logic [4:0]          p_tgt1,
    input  logic [4:0]          p_tgt2,
    input  logic [31:0]         p_data1,
    input  logic [31:0]         p_data2,
    input  logic                lat_valid,
    input  logic [4:0]          lat_tgt,
    input  logic [31:0]         lat_data,
    output logic                lat_ready,
    output logic                rf_we_a,
    output logic                rf_we_b,
    output logic [4:0]          rf_tgt_a,
    output logic [4:0]          rf_tgt_b,
    output logic [31:0]         rf_data_a,
    output logic [31:0]         rf_data_b,
    output logic                stall_req,
    output logic [31:0]         pend_mask
`ifdef WB_ARB_STATS_EN
    ,
    output logic [31:0]         stat_stall_cycles,
    output logic [31:0]         stat_lat_writes
`endif
);

    localparam int CNT_W = $clog2(LAT_DEPTH) + 1;
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]  count;
    logic [REG_W-1:0]  head_tgt, sec_tgt;
    logic [DATA_W-1:0] head_data, sec_data;
    logic              push;
    logic [1:0]        pop_cnt;
    logic              has_head, has_sec;
    logic              head_waw, head_to_a, head_to_b, head_pop;
    logic              sec_waw, sec_ok, sec_to_a, sec_to_b, sec_pop;
    logic              b_free, a_free;
    logic              we_a_d, we_b_d;
    logic [REG_W-1:0]  tgt_a_d, tgt_b_d;
    logic [DATA_W-1:0] data_a_d, data_b_d;
    logic [AGE_W-1:0]  age_q;
    logic              age_sat;
    arb_state_t        state_q, state_d;

    assign lat_ready = (count < CNT_W'(LAT_DEPTH));
    // r0 requests complete the handshake but never occupy a slot.
    assign push      = lat_valid && lat_ready && (lat_tgt != '0);
    assign stall_req = (state_q == FORCE);
    assign age_sat   = (age_q == AGE_W'(STARVE_LIMIT));

    wb_lat_fifo #(
        .LAT_DEPTH (LAT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_tgt  (lat_tgt),
        .push_data (lat_data),
        .pop_cnt   (pop_cnt),
        .head_tgt  (head_tgt),
        .head_data (head_data),
        .sec_tgt   (sec_tgt),
        .sec_data  (sec_data),
        .count     (count),
        .pend_mask (pend_mask)
    );

    // Port selection: pipeline first, then head, then second entry into what is left.
    always_comb begin
        has_head  = (count != '0);
        has_sec   = (count >= CNT_W'(2));
        head_waw  = has_head && ((p_we1 && head_tgt == p_tgt1) || (p_we2 && head_tgt == p_tgt2));
        head_to_b = has_head && !head_waw && !p_we2;
        head_to_a = has_head && !head_waw && p_we2 && !p_we1;
        head_pop  = head_waw || head_to_b || head_to_a;
        b_free    = !p_we2 && !head_to_b;
        a_free    = !p_we1 && !head_to_a;
        sec_waw   = has_sec && head_pop &&
                    ((p_we1 && sec_tgt == p_tgt1) || (p_we2 && sec_tgt == p_tgt2));
        // Two buffered writes to one register in one cycle would race; the younger waits.
        sec_ok    = has_sec && head_pop && !sec_waw && (sec_tgt != head_tgt);
        sec_to_b  = sec_ok && b_free;
        sec_to_a  = sec_ok && !b_free && a_free;
        sec_pop   = sec_waw || sec_to_b || sec_to_a;
        pop_cnt   = {1'b0, head_pop} + {1'b0, sec_pop};

        we_a_d   = p_we1 || head_to_a || sec_to_a;
        tgt_a_d  = '0;
        data_a_d = '0;
        if (p_we1) begin
            tgt_a_d  = p_tgt1;
            data_a_d = p_data1;
        end else if (head_to_a) begin
            tgt_a_d  = head_tgt;
            data_a_d = head_data;
        end else if (sec_to_a) begin
            tgt_a_d  = sec_tgt;
            data_a_d = sec_data;
        end

        we_b_d   = p_we2 || head_to_b || sec_to_b;
        tgt_b_d  = '0;
        data_b_d = '0;
        if (p_we2) begin
            tgt_b_d  = p_tgt2;
            data_b_d = p_data2;
        end else if (head_to_b) begin
            tgt_b_d  = head_tgt;
            data_b_d = head_data;
        end else if (sec_to_b) begin
            tgt_b_d  = sec_tgt;
            data_b_d = sec_data;
        end
    end

    // Registered regfile write ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_a   <= 1'b0;
            rf_we_b   <= 1'b0;
            rf_tgt_a  <= '0;
            rf_tgt_b  <= '0;
            rf_data_a <= '0;
            rf_data_b <= '0;
        end else begin
            rf_we_a   <= we_a_d;
            rf_we_b   <= we_b_d;
            rf_tgt_a  <= tgt_a_d;
            rf_tgt_b  <= tgt_b_d;
            rf_data_a <= data_a_d;
            rf_data_b <= data_b_d;
        end
    end

    // Age of the oldest buffered write since the last drain, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= '0;
        end else if (count == '0 || pop_cnt != 2'd0) begin
            age_q <= '0;
        end else if (!age_sat) begin
            age_q <= age_q + AGE_W'(1);
        end
    end

    // Starvation FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Starvation FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count != '0) state_d = WAIT;
            WAIT:    if (count == '0) state_d = IDLE;
                     else if (age_sat) state_d = FORCE;
            FORCE:   if (count == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef WB_ARB_STATS_EN
    function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, acc} + {31'b0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    // Stall cycles and buffered writes actually delivered to the regfile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stall_cycles <= '0;
            stat_lat_writes   <= '0;
        end else begin
            stat_stall_cycles <= sat_add(stat_stall_cycles, {1'b0, stall_req});
            stat_lat_writes   <= sat_add(stat_lat_writes,
                                         {1'b0, head_to_a || head_to_b} +
                                         {1'b0, sec_to_a || sec_to_b});
        end
    end
`endif

endmodule
